// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes STEP bits per clock with the ripple
// carry held in a register between slices, behind a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic             r_carry;
    logic [CNT_W-1:0] r_k;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // w_c[gi] is the carry into bit gi of the current slice.
    logic [STEP:0]    w_c;
    logic [STEP-1:0]  w_s;
    logic [WIDTH-1:0] w_part_next;

    assign w_c[0] = r_carry;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_slice
            assign w_s[gi]   = r_a[gi] ^ r_b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
        end
    endgenerate

    // New slice bits enter at the MSB end so after N slices the result is aligned.
    assign w_part_next = (r_part >> STEP) | (WIDTH'(w_s) << (WIDTH - STEP));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_part  <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> STEP;
                    r_b     <= r_b >> STEP;
                    r_part  <= w_part_next;
                    r_carry <= w_c[STEP];
                    r_k     <= r_k + 1'b1;
                    if (r_k == LAST) begin
                        // Last slice: its top-bit carry-in and carry-out give overflow.
                        r_sum   <= w_part_next;
                        r_cout  <= w_c[STEP];
                        r_ovf   <= w_c[STEP] ^ w_c[STEP-1];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule
